// File: rtl/alarm_mode_if.sv
// Signal bundle between the alarm mode controller and its surroundings
// (button synchronizers, prescaler, counters, display mux).
interface alarm_mode_if;
  // No valid/ready pairs here: inputs are levels sampled every clock (tick_1hz
  // is a one-cycle strobe), inc_* are one-cycle registered pulses the counters
  // must act on in the cycle they are high, all other outputs are levels.
  logic       tick_1hz;
  logic       mode_btn;
  logic       add_btn;
  logic       stop_btn;
  logic       alarm_en;
  logic [4:0] time_hour;
  logic [5:0] time_min;
  logic [5:0] time_sec;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;

  logic       time_run;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic       alm_inc_hour;
  logic       alm_inc_min;
  logic       show_alarm;
  logic [2:0] blink_field;
  logic       ringing;
  logic [2:0] mode_dbg;
  logic [1:0] ring_dbg;

  modport master (
    output tick_1hz, mode_btn, add_btn, stop_btn, alarm_en,
           time_hour, time_min, time_sec, alm_hour, alm_min,
    input  time_run, inc_hour, inc_min, inc_sec, alm_inc_hour, alm_inc_min,
           show_alarm, blink_field, ringing, mode_dbg, ring_dbg
  );

  modport slave (
    input  tick_1hz, mode_btn, add_btn, stop_btn, alarm_en,
           time_hour, time_min, time_sec, alm_hour, alm_min,
    output time_run, inc_hour, inc_min, inc_sec, alm_inc_hour, alm_inc_min,
           show_alarm, blink_field, ringing, mode_dbg, ring_dbg
  );
endinterface

// File: rtl/alarm_mode_ctrl.sv
// Alarm clock control: time/alarm set-mode FSM plus ring FSM sharing one tick counter.
// Optional snooze state enabled by defining ALARM_SNOOZE_EN.
module alarm_mode_ctrl #(
  parameter int TIMEOUT_S = 30,
  parameter int RING_S    = 60,
  parameter int SNOOZE_S  = 300,
  parameter int CW        = 9
) (
  input logic         clk,
  input logic         reset,
  alarm_mode_if.slave bus
);

  typedef enum logic [2:0] {
    M_RUN      = 3'd0,
    M_SET_HOUR = 3'd1,
    M_SET_MIN  = 3'd2,
    M_SET_SEC  = 3'd3,
    M_ALM_HOUR = 3'd4,
    M_ALM_MIN  = 3'd5
  } mode_t;

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_RING   = 2'd1,
    R_SNOOZE = 2'd2
  } ring_t;
`else
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RING = 2'd1
  } ring_t;
`endif

  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_S - 1);
  localparam logic [CW-1:0] RING_LAST = CW'(RING_S - 1);
  localparam logic [CW-1:0] SNZ_LAST  = CW'(SNOOZE_S - 1);

  mode_t mode_state, mode_next;
  ring_t ring_state, ring_next;

  logic          mode_q, add_q, stop_q;
  logic          mode_press, add_press, stop_press, any_press;
  logic          ring_active, set_state, stop_req, mode_adv, add_eff;
  logic          match, match_q, trig;
  logic [CW-1:0] tick_cnt, cnt_last;
  logic          tick_done;
  logic          blink;
  logic          inc_hour_r, inc_min_r, inc_sec_r, alm_inc_hour_r, alm_inc_min_r;
  logic [2:0]    field;

  assign mode_press = bus.mode_btn & ~mode_q;
  assign add_press  = bus.add_btn  & ~add_q;
  assign stop_press = bus.stop_btn & ~stop_q;
  assign any_press  = mode_press | add_press | stop_press;

  assign ring_active = (ring_state != R_IDLE);
  assign set_state   = (mode_state != M_RUN);
  // While the alarm is active, mode doubles as stop and add never edits.
  assign stop_req = stop_press | (mode_press & ring_active);
  assign mode_adv = mode_press & ~stop_press & ~ring_active;
  assign add_eff  = add_press & ~mode_press & ~ring_active & set_state;

  assign match = bus.alarm_en & (mode_state == M_RUN) &
                 (bus.time_hour == bus.alm_hour) & (bus.time_min == bus.alm_min) &
                 (bus.time_sec == 6'd0);
  assign trig  = match & ~match_q;

  // One counter serves both FSMs: the ring FSM only leaves IDLE from RUN
  // and pins the mode FSM in RUN until it returns to IDLE.
  always_comb begin
    cnt_last = TO_LAST;
    if (ring_state == R_RING)
      cnt_last = RING_LAST;
    else if (ring_active)
      cnt_last = SNZ_LAST;
  end
  assign tick_done = bus.tick_1hz & (tick_cnt == cnt_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_state <= M_RUN;
      ring_state <= R_IDLE;
    end else begin
      mode_state <= mode_next;
      ring_state <= ring_next;
    end
  end

  always_comb begin
    mode_next = mode_state;
    if (mode_adv) begin
      case (mode_state)
        M_RUN:      mode_next = M_SET_HOUR;
        M_SET_HOUR: mode_next = M_SET_MIN;
        M_SET_MIN:  mode_next = M_SET_SEC;
        M_SET_SEC:  mode_next = M_ALM_HOUR;
        M_ALM_HOUR: mode_next = M_ALM_MIN;
        default:    mode_next = M_RUN;
      endcase
    end else if (set_state && !any_press && tick_done) begin
      mode_next = M_RUN;
    end
  end

  always_comb begin
    ring_next = ring_state;
    if (!bus.alarm_en) begin
      ring_next = R_IDLE;
    end else begin
      case (ring_state)
        R_IDLE: if (trig) ring_next = R_RING;
        R_RING: begin
          if (stop_req)
            ring_next = R_IDLE;
`ifdef ALARM_SNOOZE_EN
          else if (add_press)
            ring_next = R_SNOOZE;
`endif
          else if (tick_done)
            ring_next = R_IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        R_SNOOZE: begin
          if (stop_req)
            ring_next = R_IDLE;
          else if (tick_done)
            ring_next = R_RING;
        end
`endif
        default: ring_next = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= 1'b0;
      add_q    <= 1'b0;
      stop_q   <= 1'b0;
      match_q  <= 1'b0;
      tick_cnt <= '0;
      blink    <= 1'b0;
    end else begin
      mode_q  <= bus.mode_btn;
      add_q   <= bus.add_btn;
      stop_q  <= bus.stop_btn;
      match_q <= match;

      if (ring_next != ring_state)
        tick_cnt <= '0;
      else if (ring_active) begin
        if (bus.tick_1hz) tick_cnt <= tick_cnt + 1'b1;
      end else if ((mode_next != mode_state) || !set_state || any_press)
        tick_cnt <= '0;
      else if (bus.tick_1hz)
        tick_cnt <= tick_cnt + 1'b1;

      if ((mode_next != mode_state) && (mode_next != M_RUN))
        blink <= 1'b1;
      else if (bus.tick_1hz)
        blink <= ~blink;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_hour_r     <= 1'b0;
      inc_min_r      <= 1'b0;
      inc_sec_r      <= 1'b0;
      alm_inc_hour_r <= 1'b0;
      alm_inc_min_r  <= 1'b0;
    end else begin
      inc_hour_r     <= add_eff & (mode_state == M_SET_HOUR);
      inc_min_r      <= add_eff & (mode_state == M_SET_MIN);
      inc_sec_r      <= add_eff & (mode_state == M_SET_SEC);
      alm_inc_hour_r <= add_eff & (mode_state == M_ALM_HOUR);
      alm_inc_min_r  <= add_eff & (mode_state == M_ALM_MIN);
    end
  end

  always_comb begin
    field = 3'b000;
    case (mode_state)
      M_SET_HOUR, M_ALM_HOUR: field = 3'b100;
      M_SET_MIN,  M_ALM_MIN:  field = 3'b010;
      M_SET_SEC:              field = 3'b001;
      default:                field = 3'b000;
    endcase
  end

  assign bus.time_run     = ~((mode_state == M_SET_HOUR) | (mode_state == M_SET_MIN) |
                              (mode_state == M_SET_SEC));
  assign bus.show_alarm   = (mode_state == M_ALM_HOUR) | (mode_state == M_ALM_MIN);
  assign bus.blink_field  = blink ? field : 3'b000;
  assign bus.ringing      = (ring_state == R_RING);
  assign bus.inc_hour     = inc_hour_r;
  assign bus.inc_min      = inc_min_r;
  assign bus.inc_sec      = inc_sec_r;
  assign bus.alm_inc_hour = alm_inc_hour_r;
  assign bus.alm_inc_min  = alm_inc_min_r;
  assign bus.mode_dbg     = mode_state;
  assign bus.ring_dbg     = ring_state;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Directed bench for alarm_mode_ctrl: set modes, strobes, timeout, ring and snooze.
module tb_alarm_mode_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_bad;
  int   n_str[5];   // hour, min, sec, alm_hour, alm_min pulse counts
  int   snap[5];

  alarm_mode_if bus();

  alarm_mode_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.inc_hour)     n_str[0]++;
    if (bus.inc_min)      n_str[1]++;
    if (bus.inc_sec)      n_str[2]++;
    if (bus.alm_inc_hour) n_str[3]++;
    if (bus.alm_inc_min)  n_str[4]++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic a, input logic s);
    bus.mode_btn = m;
    bus.add_btn  = a;
    bus.stop_btn = s;
    @(negedge clk);
    bus.mode_btn = 1'b0;
    bus.add_btn  = 1'b0;
    bus.stop_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.tick_1hz = 1'b1;
      @(negedge clk);
      bus.tick_1hz = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < 5; i++) snap[i] = n_str[i];
  endtask

  function automatic int delta(input int idx);
    return n_str[idx] - snap[idx];
  endfunction

  function automatic int delta_all();
    int s;
    s = 0;
    for (int i = 0; i < 5; i++) s += n_str[i] - snap[i];
    return s;
  endfunction

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus.time_hour = h;
    bus.time_min  = m;
    bus.time_sec  = s;
  endtask

  // Make the alarm minute start fresh: 07:29:59 then 07:30:00.
  task automatic ring_up();
    set_time(5'd7, 6'd29, 6'd59);
    cyc(2);
    set_time(5'd7, 6'd30, 6'd0);
    cyc(1);
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    for (int i = 0; i < 5; i++) begin
      n_str[i] = 0;
      snap[i]  = 0;
    end
    reset        = 1'b1;
    bus.tick_1hz = 1'b0;
    bus.mode_btn = 1'b0;
    bus.add_btn  = 1'b0;
    bus.stop_btn = 1'b0;
    bus.alarm_en = 1'b0;
    bus.alm_hour = 5'd7;
    bus.alm_min  = 6'd30;
    set_time(5'd12, 6'd0, 6'd0);
    cyc(3);

    check_eq("rst_time_run", bus.time_run, 1);
    check_eq("rst_ringing", bus.ringing, 0);
    check_eq("rst_show_alarm", bus.show_alarm, 0);
    check_eq("rst_blink", bus.blink_field, 3'b000);
    check_eq("rst_mode", bus.mode_dbg, 0);
    check_eq("rst_strobes", {bus.inc_hour, bus.inc_min, bus.inc_sec,
                             bus.alm_inc_hour, bus.alm_inc_min}, 0);
    reset = 1'b0;
    cyc(2);

    // Time-set path up to SET_SEC
    repeat (3) press(1, 0, 0);
    check_eq("set_sec_mode", bus.mode_dbg, 3);
    check_eq("set_sec_time_run", bus.time_run, 0);
    check_eq("set_sec_blink_entry", bus.blink_field, 3'b001);
    take_snap();
    press(0, 1, 0);
    cyc(1);
    check_eq("add_inc_sec", delta(2), 1);
    check_eq("add_only_sec", delta_all(), 1);
    take_snap();
    bus.add_btn = 1'b1;
    cyc(5);
    bus.add_btn = 1'b0;
    cyc(2);
    check_eq("held_add_one_pulse", delta(2), 1);
    ticks(1);
    check_eq("blink_tick1", bus.blink_field, 3'b000);
    ticks(1);
    check_eq("blink_tick2", bus.blink_field, 3'b001);

    // add + mode together: mode wins
    take_snap();
    press(1, 1, 0);
    cyc(1);
    check_eq("addmode_mode", bus.mode_dbg, 4);
    check_eq("addmode_no_strobe", delta_all(), 0);
    check_eq("alm_hour_show", bus.show_alarm, 1);
    check_eq("alm_hour_blink", bus.blink_field, 3'b100);
    press(1, 0, 0);
    check_eq("alm_min_mode", bus.mode_dbg, 5);
    take_snap();
    press(0, 1, 0);
    cyc(1);
    check_eq("alm_inc_min", delta(4), 1);
    check_eq("alm_only_min", delta_all(), 1);
    check_eq("alm_min_show", bus.show_alarm, 1);
    check_eq("alm_min_blink", bus.blink_field, 3'b010);
    press(1, 0, 0);
    check_eq("back_run_mode", bus.mode_dbg, 0);
    check_eq("back_run_show", bus.show_alarm, 0);
    check_eq("back_run_time_run", bus.time_run, 1);
    check_eq("back_run_blink", bus.blink_field, 3'b000);

    // Timeout from SET_MIN
    press(1, 0, 0);
    press(1, 0, 0);
    check_eq("to_enter", bus.mode_dbg, 2);
    take_snap();
    ticks(29);
    check_eq("to_tick29", bus.mode_dbg, 2);
    ticks(1);
    check_eq("to_tick30", bus.mode_dbg, 0);
    check_eq("to_no_strobe", delta_all(), 0);

    // Alarm match and ring duration
    bus.alarm_en = 1'b1;
    set_time(5'd7, 6'd29, 6'd59);
    cyc(2);
    check_eq("pre_match", bus.ringing, 0);
    set_time(5'd7, 6'd30, 6'd0);
    cyc(1);
    check_eq("match_ring", bus.ringing, 1);
    ticks(59);
    check_eq("ring_tick59", bus.ringing, 1);
    ticks(1);
    check_eq("ring_tick60", bus.ringing, 0);
    cyc(3);
    check_eq("no_retrig_same_sec", bus.ringing, 0);
    set_time(5'd7, 6'd30, 6'd1);
    cyc(3);
    check_eq("no_retrig_0731", bus.ringing, 0);

    // stop + mode together while ringing
    ring_up();
    check_eq("ring2", bus.ringing, 1);
    bus.stop_btn = 1'b1;
    bus.mode_btn = 1'b1;
    @(negedge clk);
    bus.stop_btn = 1'b0;
    bus.mode_btn = 1'b0;
    check_eq("stopmode_ringing", bus.ringing, 0);
    cyc(2);
    check_eq("stopmode_run", bus.mode_dbg, 0);

    // mode alone acts as stop
    ring_up();
    check_eq("ring3", bus.ringing, 1);
    press(1, 0, 0);
    check_eq("mode_stop_ringing", bus.ringing, 0);
    check_eq("mode_stop_run", bus.mode_dbg, 0);

    // add during ring
    ring_up();
    check_eq("ring4", bus.ringing, 1);
    take_snap();
    press(0, 1, 0);
    cyc(1);
    check_eq("add_ring_no_strobe", delta_all(), 0);
`ifdef ALARM_SNOOZE_EN
    check_eq("snooze_quiet", bus.ringing, 0);
    ticks(299);
    check_eq("snooze_tick299", bus.ringing, 0);
    ticks(1);
    check_eq("snooze_tick300", bus.ringing, 1);
`else
    check_eq("add_ignored", bus.ringing, 1);
`endif
    bus.alarm_en = 1'b0;
    @(negedge clk);
    check_eq("en_off_idle", bus.ringing, 0);

    // Async reset while ringing
    bus.alarm_en = 1'b1;
    ring_up();
    check_eq("ring5", bus.ringing, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("reset_ringing", bus.ringing, 0);
    check_eq("reset_ring_state", bus.ring_dbg, 0);
    cyc(2);
    reset = 1'b0;
    bus.alarm_en = 1'b0;
    cyc(2);

    // Reset drops a pending strobe
    press(1, 0, 0);
    check_eq("sh_mode", bus.mode_dbg, 1);
    bus.add_btn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("pending_inc_hour", bus.inc_hour, 1);
    reset = 1'b1;
    #1;
    check_eq("reset_drops_strobe", bus.inc_hour, 0);
    check_eq("reset_mode", bus.mode_dbg, 0);
    bus.add_btn = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
